// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch slice
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FULL, PAUSE} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qentry_t;
  localparam logic [31:0] INSTR_NOP = 32'h0;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory-side and decode-side signals of the fetch controller
interface fetch_if #(parameter int QDEPTH = 4);
  logic                    FetchEn;
  logic [31:0]             IMemAddr;
  logic [31:0]             IMemInstr;
  logic [31:0]             IMemLookAhead;
  logic                    BranchTaken;
  logic [31:0]             BranchTarget;
  logic [31:0]             InstrOut;
  logic [31:0]             PCOut;
  logic                    InstrValid;
  logic                    DecodeReady;
  logic [$clog2(QDEPTH):0] QueueCount;
  modport master (
    input  FetchEn, IMemInstr, IMemLookAhead, BranchTaken, BranchTarget, DecodeReady,
    output IMemAddr, InstrOut, PCOut, InstrValid, QueueCount
  );
  modport slave (
    output FetchEn, IMemInstr, IMemLookAhead, BranchTaken, BranchTarget, DecodeReady,
    input  IMemAddr, InstrOut, PCOut, InstrValid, QueueCount
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, instr} with up to two pushes per cycle and flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push0,
  input  logic    push1,
  input  logic    pop,
  input  logic    flush,
  input  qentry_t in0,
  input  qentry_t in1,
  output logic [CW-1:0] count,
  output qentry_t head
);
  qentry_t mem_q [QDEPTH];
  qentry_t mem_d [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  // second push lands directly behind the first; flush wins over everything
  always_comb begin
    mem_d = mem_q;
    if (push0) mem_d[tail_q] = in0;
    if (push1) mem_d[tail_q + PW'(1)] = in1;
    tail_d  = flush ? '0 : tail_q + PW'(push0) + PW'(push1);
    head_d  = flush ? '0 : head_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end
  // queue state register
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[head_q] : '{pc: 32'h0, instr: INSTR_NOP};
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC, fetch FSM and redirect logic feeding a small instruction queue (optional FETCH_DUAL_EN)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          QDEPTH     = 4,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'h0,
  localparam int         CW         = $clog2(QDEPTH) + 1,
  localparam int         AW         = $clog2(IMEM_WORDS)
) (
  input logic      Clk,
  input logic      Reset,
  fetch_if.master  bus
);
  fetch_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count, free;
  logic          pop, push0, push1;
  qentry_t       head;
  // push/redirect decision; a taken branch flushes and discards this cycle's pop
  always_comb begin
    pop   = bus.InstrValid & bus.DecodeReady;
    free  = CW'(QDEPTH) - count + CW'(pop);
    push0 = (state_q == RUN) && bus.FetchEn && (free != '0) && !bus.BranchTaken;
`ifdef FETCH_DUAL_EN
    push1 = push0 && (free >= CW'(2)) && (pc_q[AW+1:2] != AW'(IMEM_WORDS - 1));
`else
    push1 = 1'b0;
`endif
    pc_d = bus.BranchTaken ? (bus.BranchTarget & ~32'h3) :
           pc_q + (push1 ? 32'd8 : push0 ? 32'd4 : 32'd0);
    state_d = (state_q == BOOT) ? RUN :
              !bus.FetchEn ? PAUSE :
              (bus.BranchTaken || state_q == PAUSE || free != '0) ? RUN : FULL;
  end
  // PC and FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (Clk),
    .rst   (Reset),
    .push0 (push0),
    .push1 (push1),
    .pop   (pop & ~bus.BranchTaken),
    .flush (bus.BranchTaken),
    .in0   ('{pc: pc_q, instr: bus.IMemInstr}),
    .in1   ('{pc: pc_q + 32'd4, instr: bus.IMemLookAhead}),
    .count (count),
    .head  (head)
  );
  assign bus.IMemAddr   = 32'(pc_q[AW+1:2]);
  assign bus.InstrOut   = head.instr;
  assign bus.PCOut      = head.pc;
  assign bus.InstrValid = (count != '0);
  assign bus.QueueCount = count;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch_controller against hand-computed values
module tb_fetch_controller;
  import fetch_pkg::*;
  logic Clk = 0;
  logic Reset;
  int checks = 0;
  int passed = 0;
  fetch_if #(.QDEPTH(4)) bus ();
  fetch_controller #(.QDEPTH(4), .IMEM_WORDS(128), .RESET_PC(32'h0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );
  always #5 Clk = ~Clk;
  assign bus.IMemInstr     = {23'b0, bus.IMemAddr[6:0], 2'b00};
  assign bus.IMemLookAhead = {23'b0, bus.IMemAddr[6:0] + 7'd1, 2'b00};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset();
    Reset = 1;
    step();
    Reset = 0;
  endtask
  initial begin
    Reset = 1;
    bus.FetchEn = 1;
    bus.DecodeReady = 1;
    bus.BranchTaken = 0;
    bus.BranchTarget = 0;
    step();
    step();
    check("rst_valid", 32'(bus.InstrValid), 0);
    check("rst_count", 32'(bus.QueueCount), 0);
    check("rst_instr", bus.InstrOut, 0);
    check("rst_pcout", bus.PCOut, 0);
    check("rst_state", 32'(dut.state_q), 32'(BOOT));
    check("rst_pc", dut.pc_q, 0);
    Reset = 0;
    step();
    check("boot_state", 32'(dut.state_q), 32'(RUN));
    check("boot_nopush", 32'(bus.QueueCount), 0);
    check("boot_pc", dut.pc_q, 0);
    step();
    check("first_valid", 32'(bus.InstrValid), 1);
    check("first_pcout", bus.PCOut, 0);
    check("first_instr", bus.InstrOut, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("stream_pcout", bus.PCOut, 32'(4 * k));
      check("stream_instr", bus.InstrOut, 32'(4 * k));
      check("stream_count", 32'(bus.QueueCount), 1);
    end
    // stall: queue saturates, no overwrite
    do_reset();
    bus.DecodeReady = 0;
    for (int k = 0; k < 10; k++) step();
    check("stall_count", 32'(bus.QueueCount), 4);
    check("stall_state", 32'(dut.state_q), 32'(FULL));
    check("stall_pc", dut.pc_q, 32'h10);
    check("stall_head", bus.PCOut, 0);
    bus.DecodeReady = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("drain_pcout", bus.PCOut, 32'(4 * k));
      check("drain_instr", bus.InstrOut, 32'(4 * k));
    end
    check("drain_count", 32'(bus.QueueCount), 3);
    // redirect with three queued entries and a simultaneous pop
    bus.BranchTaken = 1;
    bus.BranchTarget = 32'h47;
    step();
    bus.BranchTaken = 0;
    check("br_count", 32'(bus.QueueCount), 0);
    check("br_valid", 32'(bus.InstrValid), 0);
    check("br_pc", dut.pc_q, 32'h44);
    step();
    check("br_pcout", bus.PCOut, 32'h44);
    check("br_instr", bus.InstrOut, 32'h44);
    // word index wrap 127 -> 0
    bus.BranchTaken = 1;
    bus.BranchTarget = 32'h1FC;
    step();
    bus.BranchTaken = 0;
    check("wrap_addr127", bus.IMemAddr, 127);
    step();
    check("wrap_addr0", bus.IMemAddr, 0);
    check("wrap_pcout", bus.PCOut, 32'h1FC);
    check("wrap_instr", bus.InstrOut, 32'h1FC);
    check("wrap_count", 32'(bus.QueueCount), 1);
    step();
    check("wrap_pcout2", bus.PCOut, 32'h200);
    check("wrap_instr2", bus.InstrOut, 32'h0);
`ifdef FETCH_DUAL_EN
    check("wrap_dual_count", 32'(bus.QueueCount), 2);
    do_reset();
    bus.DecodeReady = 0;
    step();
    step();
    check("dual_count", 32'(bus.QueueCount), 2);
    check("dual_pc", dut.pc_q, 32'h8);
`else
    check("wrap_single_count", 32'(bus.QueueCount), 1);
    do_reset();
    bus.DecodeReady = 0;
    step();
    step();
    check("single_count", 32'(bus.QueueCount), 1);
    step();
`endif
    // pause drains the queue without fetching
    check("pause_pre_count", 32'(bus.QueueCount), 2);
    bus.FetchEn = 0;
    bus.DecodeReady = 1;
    step();
    check("pause_state", 32'(dut.state_q), 32'(PAUSE));
    check("pause_pcout", bus.PCOut, 32'h4);
    step();
    check("pause_count", 32'(bus.QueueCount), 0);
    check("pause_valid", 32'(bus.InstrValid), 0);
    check("pause_pc", dut.pc_q, 32'h8);
    check("pause_instr", bus.InstrOut, 0);
    bus.FetchEn = 1;
    step();
    check("resume_state", 32'(dut.state_q), 32'(RUN));
    step();
    check("resume_pcout", bus.PCOut, 32'h8);
    // reset overrides a simultaneous branch
    Reset = 1;
    bus.BranchTaken = 1;
    bus.BranchTarget = 32'h100;
    step();
    Reset = 0;
    bus.BranchTaken = 0;
    check("mid_rst_count", 32'(bus.QueueCount), 0);
    check("mid_rst_valid", 32'(bus.InstrValid), 0);
    check("mid_rst_pcout", bus.PCOut, 0);
    check("mid_rst_instr", bus.InstrOut, 0);
    check("mid_rst_pc", dut.pc_q, 0);
    check("mid_rst_state", 32'(dut.state_q), 32'(BOOT));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
